rtn_addr_stack: RTL and testbench

Hardware return-address stack for the RISC core. It sits beside the program-counter block. On a call it captures the address to resume at (the caller's PC + 1). On a return it presents that address on `return_addr`, the port the program counter loads from. The stack is LIFO with a fixed depth, and it keeps sticky overflow/underflow error flags for the control FSM and debug.

---
 rtl/rtn_addr_stack.sv | 101 ++++++++++
 tb/tb_rtn_addr_stack.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rtn_addr_stack.sv
// rtl/rtn_addr_stack.sv - LIFO return-address stack for the core's call/return path
// Holds caller PC+1 on call, presents top-of-stack for the PC to load on return.
module rtn_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_addr,
  input  logic                     clr_err,
  output logic [AW-1:0]            return_addr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [IW:0]   sp_q, sp_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          we;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          ovf_set;
  logic          udf_set;
  logic          is_empty;
  logic          is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == DEPTH_C);
  assign top_idx  = IW'(sp_q - 1'b1);

  assign return_addr = is_empty ? '0 : mem_q[top_idx];
  assign empty       = is_empty;
  assign full        = is_full;
  assign level       = sp_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // Saturation comes from the full/empty guards, so sp never wraps.
  always_comb begin
    sp_d    = sp_q;
    we      = 1'b0;
    wr_idx  = IW'(sp_q);
    ovf_set = 1'b0;
    udf_set = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          we     = 1'b1;
          wr_idx = IW'(sp_q);
          sp_d   = sp_q + 1'b1;
        end
      end
      2'b01: begin
        if (is_empty) udf_set = 1'b1;
        else          sp_d    = sp_q - 1'b1;
      end
      2'b11: begin
        // Tail call: overwrite the top; on an empty stack behave as a plain push.
        we = 1'b1;
        if (is_empty) begin
          wr_idx = '0;
          sp_d   = (IW+1)'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
    overflow_d  = ovf_set | (overflow_q  & ~clr_err);
    underflow_d = udf_set | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && reset) mem_q[wr_idx] <= push_addr;
  end

endmodule

// File: tb/tb_rtn_addr_stack.sv
// tb/tb_rtn_addr_stack.sv - scoreboard bench for rtn_addr_stack
module tb_rtn_addr_stack;

  typedef struct {
    logic [7:0] ra;
    logic [3:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] push_addr = '0;
  logic       clr_err = 1'b0;
  logic [7:0] return_addr;
  logic       empty;
  logic       full;
  logic [3:0] level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int passes = 0;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  rtn_addr_stack #(.DEPTH(8), .AW(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_addr(push_addr),
    .clr_err(clr_err), .return_addr(return_addr), .empty(empty), .full(full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, " return_addr"}, int'(return_addr), int'(e.ra));
      chk({e.tag, " level"},       int'(level),       int'(e.lvl));
      chk({e.tag, " full"},        int'(full),        int'(e.full));
      chk({e.tag, " empty"},       int'(empty),       int'(e.empty));
      chk({e.tag, " overflow"},    int'(overflow),    int'(e.ovf));
      chk({e.tag, " underflow"},   int'(underflow),   int'(e.udf));
    end
  end

  // Directed step: expected values are the outputs visible during this cycle.
  task automatic step(input string tag, input logic p, input logic q, input logic [7:0] a,
                      input logic c, input logic [7:0] ra, input int lvl, input logic f,
                      input logic e, input logic o, input logic u);
    exp_t x;
    @(posedge clk); #1;
    x.ra = ra; x.lvl = 4'(lvl); x.full = f; x.empty = e; x.ovf = o; x.udf = u; x.tag = tag;
    exp_q.push_back(x);
    push = p; pop = q; push_addr = a; clr_err = c;
  endtask

  // Random step: expectation from the queue model, then the model advances.
  task automatic rstep(input logic p, input logic q, input logic [7:0] a, input logic c);
    exp_t x;
    int   n;
    @(posedge clk); #1;
    n = model_q.size();
    x.ra = (n == 0) ? 8'h00 : model_q[n-1];
    x.lvl = 4'(n); x.full = (n == 8); x.empty = (n == 0);
    x.ovf = m_ovf; x.udf = m_udf; x.tag = "rand";
    exp_q.push_back(x);
    push = p; pop = q; push_addr = a; clr_err = c;
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (p && q) begin
      if (n != 0) void'(model_q.pop_back());
      model_q.push_back(a);
    end else if (p) begin
      if (n == 8) m_ovf = 1'b1;
      else        model_q.push_back(a);
    end else if (q) begin
      if (n == 0) m_udf = 1'b1;
      else        void'(model_q.pop_back());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    model_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #12 reset = 1'b1;
    step("rst_idle", 0,0,8'h00,0, 8'h00,0,0,1,0,0);

    step("nest_p11", 1,0,8'h11,0, 8'h00,0,0,1,0,0);
    step("nest_p22", 1,0,8'h22,0, 8'h11,1,0,0,0,0);
    step("nest_p33", 1,0,8'h33,0, 8'h22,2,0,0,0,0);
    step("nest_top", 0,0,8'h00,0, 8'h33,3,0,0,0,0);
    step("nest_pop1",0,1,8'h00,0, 8'h33,3,0,0,0,0);
    step("nest_pop2",0,1,8'h00,0, 8'h22,2,0,0,0,0);
    step("nest_pop3",0,1,8'h00,0, 8'h11,1,0,0,0,0);
    step("nest_end", 0,0,8'h00,0, 8'h00,0,0,1,0,0);

    for (int k = 1; k <= 8; k++)
      step("ovf_fill", 1,0,8'(k),0, 8'(k-1),k-1,0,(k==1),0,0);
    step("ovf_push9", 1,0,8'h09,0, 8'h08,8,1,0,0,0);
    step("ovf_flag",  0,0,8'h00,0, 8'h08,8,1,0,1,0);
    for (int i = 0; i < 8; i++)
      step("ovf_drain", 0,1,8'h00,0, 8'(8-i),8-i,(i==0),0,1,0);
    step("ovf_empty", 0,0,8'h00,0, 8'h00,0,0,1,1,0);
    step("ovf_clr",   0,0,8'h00,1, 8'h00,0,0,1,1,0);
    step("ovf_clred", 0,0,8'h00,0, 8'h00,0,0,1,0,0);

    step("udf_pop",     0,1,8'h00,0, 8'h00,0,0,1,0,0);
    step("udf_flag",    0,0,8'h00,0, 8'h00,0,0,1,0,1);
    step("udf_clrpop",  0,1,8'h00,1, 8'h00,0,0,1,0,1);
    step("udf_setwins", 0,0,8'h00,0, 8'h00,0,0,1,0,1);
    step("udf_clr",     0,0,8'h00,1, 8'h00,0,0,1,0,1);
    step("udf_clred",   0,0,8'h00,0, 8'h00,0,0,1,0,0);

    step("pp_p40",   1,0,8'h40,0, 8'h00,0,0,1,0,0);
    step("pp_rep55", 1,1,8'h55,0, 8'h40,1,0,0,0,0);
    step("pp_top55", 0,0,8'h00,0, 8'h55,1,0,0,0,0);
    step("pp_pop",   0,1,8'h00,0, 8'h55,1,0,0,0,0);
    step("pp_e66",   1,1,8'h66,0, 8'h00,0,0,1,0,0);
    step("pp_top66", 0,0,8'h00,0, 8'h66,1,0,0,0,0);
    step("pp_pop66", 0,1,8'h00,0, 8'h66,1,0,0,0,0);
    step("pp_end",   0,0,8'h00,0, 8'h00,0,0,1,0,0);

    step("ar_pa1", 1,0,8'hA1,0, 8'h00,0,0,1,0,0);
    step("ar_pa2", 1,0,8'hA2,0, 8'hA1,1,0,0,0,0);
    step("ar_pa3", 1,0,8'hA3,0, 8'hA2,2,0,0,0,0);
    step("ar_lvl", 0,0,8'h00,0, 8'hA3,3,0,0,0,0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rst level", int'(level), 0);
    chk("async_rst empty", int'(empty), 1);
    chk("async_rst return_addr", int'(return_addr), 0);
    chk("async_rst full", int'(full), 0);
    @(negedge clk);
    reset = 1'b1;
    step("ar_after", 0,0,8'h00,0, 8'h00,0,0,1,0,0);

    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rstep(r < 45, (r >= 35) && (r < 85), 8'($urandom), $urandom_range(0, 19) == 0);
    end

    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
